// File: rtl/fetch_ctrl.sv
// Decode-side control stage: issues fetched instructions to execute and steers fetch
// through jumps, CALL/RET (return-address stack), load-use/flag hazards, squash and HALT.
module fetch_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int RAS_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] ins,
  input  logic [7:0]  ins_addr,
  input  logic        zero_flag,
  input  logic        carry_flag,
  output logic [19:0] dec_ins,
  output logic [7:0]  dec_pc,
  output logic        dec_valid,
  output logic        stall,
  output logic        stall_pm,
  output logic        pc_mux_sel,
  output logic [7:0]  jmp_loc,
  output logic        halted,
  output logic        ras_err
);

  localparam int SPW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_LOAD = 5'b10100;
  localparam logic [4:0] OP_JMP  = 5'b11000;
  localparam logic [4:0] OP_JZ   = 5'b11001;
  localparam logic [4:0] OP_JNZ  = 5'b11010;
  localparam logic [4:0] OP_JC   = 5'b11011;
  localparam logic [4:0] OP_CALL = 5'b11100;
  localparam logic [4:0] OP_RET  = 5'b11101;
  localparam logic [4:0] OP_HALT = 5'b11111;

  typedef enum logic [1:0] {ST_RUN, ST_SQUASH, ST_HALT} state_t;

  state_t         r_state, w_state_nxt;
  logic [1:0]     r_sq_cnt, w_sq_cnt_nxt;
  logic [7:0]     r_ras [RAS_DEPTH];
  logic [SPW-1:0] r_sp;   // next free slot; top of stack is r_sp-1
  logic [SPW:0]   r_cnt;

  logic [4:0] w_op, w_rs1, w_rs2, w_dop, w_drd;
  logic       w_is_ctrl, w_is_bcc, w_dec_alu;
  logic       w_load_use, w_flag_haz, w_taken;
  logic       w_ras_empty, w_ras_full;
  logic [7:0] w_ras_top;
  logic       w_stall, w_pc_sel;
  logic [7:0] w_jmp;
  logic       w_issue, w_bubble, w_push, w_pop, w_halt_set;

  assign w_op  = ins[19:15];
  assign w_rs1 = ins[9:5];
  assign w_rs2 = ins[4:0];
  assign w_dop = dec_ins[19:15];
  assign w_drd = dec_ins[14:10];

  assign w_is_ctrl = (w_op[4:3] == 2'b11);
  assign w_is_bcc  = (w_op == OP_JZ) || (w_op == OP_JNZ) || (w_op == OP_JC);
  assign w_dec_alu = (w_dop[4] == 1'b0) && (w_dop != OP_NOP);

  assign w_load_use = dec_valid && (w_dop == OP_LOAD) && !w_is_ctrl &&
                      ((w_rs1 == w_drd) || (w_rs2 == w_drd));
  assign w_flag_haz = w_is_bcc && dec_valid && w_dec_alu;

  always_comb begin
    case (w_op)
      OP_JMP, OP_CALL, OP_RET: w_taken = 1'b1;
      OP_JZ:                   w_taken = zero_flag;
      OP_JNZ:                  w_taken = !zero_flag;
      OP_JC:                   w_taken = carry_flag;
      default:                 w_taken = 1'b0;
    endcase
  end

  assign w_ras_empty = (r_cnt == '0);
  assign w_ras_full  = (r_cnt == (SPW+1)'(RAS_DEPTH));
  assign w_ras_top   = r_ras[r_sp - SPW'(1)];

  always_comb begin
    w_stall      = 1'b0;
    w_pc_sel     = 1'b0;
    w_jmp        = 8'h00;
    w_issue      = 1'b0;
    w_bubble     = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_halt_set   = 1'b0;
    w_state_nxt  = r_state;
    w_sq_cnt_nxt = r_sq_cnt;
    case (r_state)
      ST_HALT: w_stall = 1'b1;
      ST_SQUASH: begin
        w_bubble     = 1'b1;
        w_sq_cnt_nxt = r_sq_cnt - 2'd1;
        if (r_sq_cnt <= 2'd1) w_state_nxt = ST_RUN;
      end
      default: begin
        if (w_load_use || w_flag_haz) begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
        end else if (w_taken) begin
          w_pc_sel     = 1'b1;
          w_issue      = 1'b1;
          w_push       = (w_op == OP_CALL);
          w_pop        = (w_op == OP_RET);
          // RET on an empty stack falls back to address 0
          w_jmp        = (w_op == OP_RET) ? (w_ras_empty ? 8'h00 : w_ras_top) : ins[7:0];
          w_state_nxt  = ST_SQUASH;
          w_sq_cnt_nxt = 2'(FLUSH_CYCLES);
        end else begin
          w_issue = 1'b1;
          if (w_op == OP_HALT) begin
            w_halt_set  = 1'b1;
            w_state_nxt = ST_HALT;
          end
        end
      end
    endcase
  end

  // Fetch controls are forced quiet while reset is held
  assign stall      = w_stall  && !reset;
  assign stall_pm   = w_stall  && !reset;
  assign pc_mux_sel = w_pc_sel && !reset;
  assign jmp_loc    = reset ? 8'h00 : w_jmp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_sq_cnt <= 2'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_sq_cnt <= w_sq_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_ins   <= 20'h0;
      dec_pc    <= 8'h00;
      dec_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      if (w_issue) begin
        dec_ins   <= ins;
        dec_pc    <= ins_addr;
        dec_valid <= 1'b1;
      end else if (w_bubble) begin
        dec_ins   <= 20'h0;
        dec_valid <= 1'b0;
      end else begin
        dec_valid <= 1'b0;
      end
      if (w_halt_set) halted <= 1'b1;
    end
  end

  // Circular stack: overflow overwrites the oldest entry, count saturates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= 8'h00;
      r_sp    <= '0;
      r_cnt   <= '0;
      ras_err <= 1'b0;
    end else if (w_push) begin
      r_ras[r_sp] <= ins_addr + 8'd1;
      r_sp        <= r_sp + SPW'(1);
      if (w_ras_full) ras_err <= 1'b1;
      else            r_cnt   <= r_cnt + (SPW+1)'(1);
    end else if (w_pop) begin
      if (w_ras_empty) begin
        ras_err <= 1'b1;
      end else begin
        r_sp  <= r_sp - SPW'(1);
        r_cnt <= r_cnt - (SPW+1)'(1);
      end
    end
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Decode-side control stage that sits directly downstream of instruction fetch. It takes each 20-bit fetched instruction and its address, and issues it to execute as a registered instruction/PC/valid triple. It drives the fetch controls back upstream: `stall`, `stall_pm`, `pc_mux_sel` and `jmp_loc`. It resolves jumps, CALL/RET through a small return-address stack, load-use and flag hazards, wrong-path squashing and HALT.

## Interface
- `FLUSH_CYCLES`, default 1: wrong-path instructions discarded after a taken jump (1–3).
- `RAS_DEPTH`, default 4: return-address stack entries (power of two).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ins`  in  20  instruction currently presented by fetch.
- `ins_addr`  in  8  address of `ins`.
- `zero_flag`, `carry_flag`  in  1 each  execute-stage flags, valid for the instruction issued two or more cycles earlier.
- `dec_ins`  out  20  issued instruction (registered).
- `dec_pc`  out  8  address of `dec_ins` (registered).
- `dec_valid`  out  1  `dec_ins` is real, not a bubble (registered).
- `stall`  out  1  fetch holds its address.
- `stall_pm`  out  1  fetch re-presents the held instruction.
- `pc_mux_sel`  out  1  fetch loads `jmp_loc`.
- `jmp_loc`  out  8  jump target.
- `halted`  out  1  HALT retired (registered).
- `ras_err`  out  1  sticky: stack overflow or underflow.

## Operation
- Instruction fields: opcode `[19:15]`, rd `[14:10]`, rs1 `[9:5]`, rs2 `[4:0]`, jump target `[7:0]`.
- Opcodes:
  - NOP: 00000.
  - ALU, flag-setting: 00001–01111.
  - LOAD: 10100.
  - JMP: 11000.
  - JZ: 11001.
  - JNZ: 11010.
  - JC: 11011.
  - CALL: 11100.
  - RET: 11101.
  - HALT: 11111.
  - All other 1xxxx codes are non-flag ops that read rs1 and rs2.
- Control opcodes are 11000–11111. They read no registers.
- States: RUN, SQUASH, HALT.
- Evaluation order each cycle, first match wins:
  - **HALT state**: `stall`=`stall_pm`=1, `pc_mux_sel`=0, `dec_valid`←0. The state is left only by reset.
  - **SQUASH state**: `ins` is ignored and no stall is raised. `dec_ins`←0 and `dec_valid`←0. The squash counter decrements; on reaching 0 the state returns to RUN.
  - **Load-use hazard**: `dec_valid`, `dec_ins` is LOAD, `ins` is non-control, and (rs1==rd_dec or rs2==rd_dec). Action: `stall`=`stall_pm`=1, bubble issued (`dec_ins`←0, `dec_valid`←0).
  - **Flag hazard**: `ins` is JZ/JNZ/JC, `dec_valid`, and `dec_ins` opcode is 00001–01111. Action: one-cycle stall plus bubble, as for load-use.
  - **Jump taken**: JMP, CALL and RET always; JZ if `zero_flag`; JNZ if !`zero_flag`; JC if `carry_flag`.
    - `pc_mux_sel`=1.
    - `jmp_loc` = `ins[7:0]`, or the stack top for RET.
    - The jump itself issues with `dec_valid`←1.
    - State→SQUASH with counter←`FLUSH_CYCLES`.
  - **Otherwise**: issue `ins`: `dec_ins`←`ins`, `dec_pc`←`ins_addr`, `dec_valid`←1.
  - HALT in `ins` issues, sets `halted`, and enters the HALT state.
- Return-address stack:
  - CALL pushes `ins_addr`+1, mod 256 (255→0).
  - RET pops.
  - Push when full overwrites the oldest entry (circular) and sets `ras_err`.
  - Pop when empty gives `jmp_loc`=0x00, leaves the pointer unchanged and sets `ras_err`.
- `stall` and `pc_mux_sel` are never high in the same cycle.
- `jmp_loc` is 0 whenever `pc_mux_sel`=0.

## Timing
- Reset (asynchronous, immediate) clears:
  - `dec_ins`=0, `dec_pc`=0, `dec_valid`=0.
  - `halted`=0, `ras_err`=0.
  - Stack emptied; state RUN; squash counter 0.
- While `reset` is high, `stall`, `stall_pm`, `pc_mux_sel` and `jmp_loc` are all 0.
- `stall`, `stall_pm`, `pc_mux_sel` and `jmp_loc` are combinational from `ins`, the state and `dec_*`, valid in the same cycle.
- `dec_*`, `halted` and `ras_err` update on the next rising edge.
- Issue latency is 1 cycle from `ins` to `dec_ins`.
- A load-use or flag stall costs exactly 1 bubble. The held instruction is re-evaluated next cycle and issues, because `dec_valid` is then 0.
- A taken jump costs `FLUSH_CYCLES` bubbles. The target instruction is evaluated in RUN on the cycle after SQUASH ends.
- Reset asserted mid-SQUASH or mid-HALT aborts immediately. Stack contents are lost.

## Test plan
- **Straight line**: ALU ops at 0x00..0x03 → `dec_pc` 0x00..0x03 on consecutive cycles, `dec_valid`=1, no stall.
- **Load-use**: LOAD rd=3, then ADD rs1=3 → `stall`=`stall_pm`=1 for 1 cycle, then one bubble, then ADD issues. With ADD rs1=4 there is no stall.
- **JZ with flag hazard**: ADD, then JZ 0x40 with `zero_flag`=1 → 1 stall cycle, then `pc_mux_sel`=1 and `jmp_loc`=0x40, then 1 squash bubble. With `zero_flag`=0 the JZ issues with no jump.
- **CALL/RET**: CALL 0x20 at 0x05, then RET → `jmp_loc`=0x20, later 0x06. Five nested CALLs with `RAS_DEPTH`=4 → `ras_err`=1. RET on an empty stack → `jmp_loc`=0x00 and `ras_err`=1.
- **CALL wrap**: CALL at 0xFF → pushed value 0x00.
- **HALT then reset**: HALT → `halted`=1, `stall`=1 indefinitely. Asserting `reset` mid-squash or mid-halt → all outputs 0 in the same cycle. After release, normal issue resumes.
